decoder_scan: RTL and testbench

- Parametrised, registered successor to the combinational binary-to-one-hot decoders used for select and strobe generation.
- Decodes an IN_W-bit index to a 2^IN_W one-hot output.
- Adds direct-load, auto-scan up/down with programmable dwell, hold mode, output enable and a wrap pulse.
- Drives row/column select strobes and round-robin channel selects.

---
 rtl/decoder_scan.sv | 71 +++++++
 tb/tb_decoder_scan.sv | 129 ++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered index-to-one-hot decoder with direct load,
// up/down auto-scan with programmable dwell, hold, output enable and wrap pulse.
module decoder_scan #(
    parameter int IN_W = 3,
    parameter int DWELL_W = 8,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               en,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_idx,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic [IN_W-1:0]    out_idx,
    output logic               out_valid,
    output logic               wrap
);
    localparam logic [1:0] DIRECT = 2'b00;
    localparam logic [1:0] UP     = 2'b01;
    localparam logic [1:0] HOLD   = 2'b11;

    logic [DWELL_W-1:0] cnt, cnt_next;
    logic [IN_W-1:0]    idx_next;
    logic [1:0]         mode_q;
    logic               chg, step, wrap_next;

    assign chg = mode != mode_q;

    // Priority: hold freezes everything, then load, then mode change / direct clear, then scan.
    always_comb begin
        idx_next = out_idx;
        cnt_next = cnt;
        step     = 1'b0;
        if (mode == HOLD) begin
            cnt_next = chg ? '0 : cnt;
        end else if (in_valid) begin
            idx_next = in_idx;
            cnt_next = '0;
        end else if (chg || mode == DIRECT) begin
            cnt_next = '0;
        end else if (cnt == dwell) begin
            cnt_next = '0;
            step     = 1'b1;
            idx_next = mode == UP ? out_idx + 1'b1 : out_idx - 1'b1;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    assign wrap_next = step && (mode == UP ? out_idx == {IN_W{1'b1}} : out_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mode_q    <= DIRECT;
            out       <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            mode_q    <= mode;
            out       <= en ? OUT_W'(1) << idx_next : '0;
            out_idx   <= idx_next;
            out_valid <= en;
            wrap      <= wrap_next;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed and random stimulus against a cycle-level reference model.
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = '0;
    logic [7:0] dwell = '0;
    logic [7:0] out;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       wrap;

    int total = 0;
    int bad = 0;
    int m_idx = 0, m_cnt = 0, m_modeq = 0;
    int e_out = 0, e_idx = 0, e_valid = 0, e_wrap = 0;

    decoder_scan #(.IN_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .in_valid(in_valid),
        .in_idx(in_idx), .dwell(dwell), .out(out), .out_idx(out_idx),
        .out_valid(out_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out"}, int'(out), e_out);
        chk({tag, ".out_idx"}, int'(out_idx), e_idx);
        chk({tag, ".out_valid"}, int'(out_valid), e_valid);
        chk({tag, ".wrap"}, int'(wrap), e_wrap);
    endtask

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_modeq = 0;
        e_out = 0; e_idx = 0; e_valid = 0; e_wrap = 0;
    endtask

    // One clock of the behaviour rules, applied to the inputs present at the edge.
    task automatic model_edge();
        int md = int'(mode);
        int ni = m_idx;
        int nc = m_cnt;
        int w = 0;
        bit changed = md != m_modeq;
        case (md)
            3: nc = changed ? 0 : m_cnt;
            default: begin
                if (in_valid) begin ni = int'(in_idx); nc = 0; end
                else if (changed || md == 0) nc = 0;
                else if (m_cnt == int'(dwell)) begin
                    nc = 0;
                    ni = md == 1 ? (m_idx + 1) % 8 : (m_idx + 7) % 8;
                    w = (md == 1 && m_idx == 7) || (md == 2 && m_idx == 0);
                end else nc = (m_cnt + 1) % 256;
            end
        endcase
        m_idx = ni; m_cnt = nc; m_modeq = md;
        e_out = en ? (1 << ni) : 0;
        e_idx = ni; e_valid = int'(en); e_wrap = w;
    endtask

    task automatic step(input string tag, input logic [1:0] m, input logic e, input logic v,
                        input logic [2:0] i, input logic [7:0] d);
        mode = m; en = e; in_valid = v; in_idx = i; dwell = d;
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        chk_all("reset");
        #11 rst_n = 1'b1;
        // direct decode
        step("direct0", 2'b00, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("direct0.onehot01", int'(out), 8'h01);
        step("load5", 2'b00, 1'b1, 1'b1, 3'd5, 8'd0);
        chk("load5.onehot20", int'(out), 8'h20);
        step("direct_hold", 2'b00, 1'b1, 1'b0, 3'd2, 8'd0);
        // scan up dwell=2 from 6 through the wrap
        step("load6", 2'b00, 1'b1, 1'b1, 3'd6, 8'd2);
        for (int k = 0; k < 12; k++) step("scan_up_d2", 2'b01, 1'b1, 1'b0, 3'd0, 8'd2);
        // scan down dwell=0 from 1
        step("load1", 2'b00, 1'b1, 1'b1, 3'd1, 8'd0);
        for (int k = 0; k < 6; k++) step("scan_dn_d0", 2'b10, 1'b1, 1'b0, 3'd0, 8'd0);
        // load colliding with the 7->0 step
        step("load6b", 2'b01, 1'b1, 1'b1, 3'd6, 8'd0);
        step("to7", 2'b01, 1'b1, 1'b0, 3'd0, 8'd0);
        step("collide", 2'b01, 1'b1, 1'b1, 3'd0, 8'd0);
        chk("collide.nowrap", int'(wrap), 0);
        step("after_collide", 2'b01, 1'b1, 1'b0, 3'd0, 8'd0);
        chk("after_collide.idx1", int'(out_idx), 1);
        // disabled scan keeps running, then hold ignores loads
        for (int k = 0; k < 4; k++) step("en_off", 2'b01, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int k = 0; k < 3; k++) step("hold", 2'b11, 1'b1, 1'b1, 3'd3, 8'd0);
        step("hold_off", 2'b11, 1'b0, 1'b0, 3'd0, 8'd0);
        step("hold_on", 2'b11, 1'b1, 1'b0, 3'd0, 8'd0);
        // async reset mid-scan
        for (int k = 0; k < 5; k++) step("prereset", 2'b01, 1'b1, 1'b0, 3'd0, 8'd1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step("post_reset", 2'b01, 1'b1, 1'b0, 3'd0, 8'd1);
        // dwell lowered below the running count: counter must roll through all-ones
        for (int k = 0; k < 4; k++) step("dwell_hi", 2'b01, 1'b1, 1'b0, 3'd0, 8'd5);
        for (int k = 0; k < 262; k++) step("dwell_lo", 2'b01, 1'b1, 1'b0, 3'd0, 8'd1);
        // random mix
        for (int k = 0; k < 400; k++)
            step("rand", 2'($urandom_range(3, 0)), 1'($urandom_range(9, 0) != 0),
                 1'($urandom_range(7, 0) == 0), 3'($urandom), 8'($urandom_range(3, 0)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
